// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic sample generator: wave codes, the
// sequencer state type and the note-to-phase-step constant function.
package synth_pkg;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_MIX   = 2'd2
  } state_t;

  // Phase increment per sample for MIDI note `note`, equal-tempered around A4 = 440 Hz.
  function automatic logic [63:0] step_calc(input int note, input int nbits, input int rate);
    real freq;
    real step;
    freq = 440.0 * (2.0 ** ((real'(note) - 69.0) / 12.0));
    step = (2.0 ** real'(nbits)) * freq / real'(rate);
    return 64'(longint'(step));
  endfunction

endpackage

// File: rtl/freq_step_rom.sv
// Combinational note-number to phase-step table, filled at elaboration time.
module freq_step_rom
  import synth_pkg::*;
#(
  parameter int N    = 32,
  parameter int RATE = 48000
) (
  input  logic [6:0]   note,
  output logic [N-1:0] step
);

  logic [N-1:0] step_table [128];

  for (genvar g = 0; g < 128; g++) begin : g_tab
    localparam logic [N-1:0] STEP_G = N'(step_calc(g, N, RATE));
    assign step_table[g] = STEP_G;
  end

  assign step = step_table[note];

endmodule

// File: rtl/poly_sample_generator.sv
// Polyphonic oscillator bank: one voice per cycle is advanced and mixed after each
// sample strobe. Define POLY_SAMPLE_GENERATOR_TRIANGLE_EN to enable the triangle wave.
module poly_sample_generator
  import synth_pkg::*;
#(
  parameter int VOICES               = 4,
  parameter int N                    = 32,
  parameter int M                    = 12,
  parameter int SAMPLE_CLOCK_RATE_HZ = 48000
) (
  input  logic                      inCLK,
  input  logic                      inRST_N,
  input  logic                      inSampleClockCE,
  input  logic                      inNoteValid,
  input  logic                      inNoteOn,
  input  logic [$clog2(VOICES)-1:0] inNoteVoice,
  input  logic [6:0]                inNoteIndex,
  input  logic [1:0]                inNoteWave,
  output logic [M-1:0]              outSample,
  output logic                      outSampleValid,
  output logic                      outBusy,
  output logic                      outOverrun
);

  localparam int VW = $clog2(VOICES);
  localparam int AW = M + VW;

  // Handshake: inSampleClockCE is a one-cycle strobe honoured only while outBusy is low;
  // the result appears as a one-cycle outSampleValid pulse VOICES+1 cycles later.
  logic          gate  [VOICES];
  logic [6:0]    note  [VOICES];
  logic [1:0]    wave  [VOICES];
  logic [N-1:0]  phase [VOICES];

  state_t               state;
  logic [VW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_shr;
  logic [N-1:0]         step;
  logic [M-1:0]         raw;
  logic [M-1:0]         contrib;

  freq_step_rom #(.N(N), .RATE(SAMPLE_CLOCK_RATE_HZ)) u_rom (
    .note (note[cnt]),
    .step (step)
  );

  // Waveform of the voice in the current sweep slot, from its pre-update phase.
  always_comb begin
    raw = phase[cnt][N-1:N-M];
    if (wave[cnt] == WAVE_SQUARE) raw = {M{phase[cnt][N-1]}};
`ifdef POLY_SAMPLE_GENERATOR_TRIANGLE_EN
    else if (wave[cnt] == WAVE_TRI) raw = phase[cnt][N-2:N-M-1] ^ {M{phase[cnt][N-1]}};
`endif
    contrib = gate[cnt] ? {~raw[M-1], raw[M-2:0]} : '0;
  end

  assign acc_shr = acc >>> VW;

  // Note commands are written after the sweep update so a note-on clear wins.
  always_ff @(posedge inCLK or negedge inRST_N) begin
    if (!inRST_N) begin
      for (int i = 0; i < VOICES; i++) begin
        gate[i]  <= 1'b0;
        note[i]  <= '0;
        wave[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (state == ST_SWEEP && cnt == VW'(i) && gate[i]) phase[i] <= phase[i] + step;
        if (inNoteValid && inNoteVoice == VW'(i)) begin
          if (inNoteOn) begin
            gate[i]  <= 1'b1;
            note[i]  <= inNoteIndex;
            wave[i]  <= inNoteWave;
            phase[i] <= '0;
          end else begin
            gate[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge inCLK or negedge inRST_N) begin
    if (!inRST_N) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      acc            <= '0;
      outSample      <= '0;
      outSampleValid <= 1'b0;
      outBusy        <= 1'b0;
      outOverrun     <= 1'b0;
    end else begin
      outSampleValid <= 1'b0;
      if (inSampleClockCE && state != ST_IDLE) outOverrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (inSampleClockCE) begin
            state   <= ST_SWEEP;
            cnt     <= '0;
            acc     <= '0;
            outBusy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          acc <= acc + {{VW{contrib[M-1]}}, contrib};
          if (cnt == VW'(VOICES - 1)) state <= ST_MIX;
          else cnt <= cnt + 1'b1;
        end
        ST_MIX: begin
          outSample      <= acc_shr[M-1:0];
          outSampleValid <= 1'b1;
          outBusy        <= 1'b0;
          state          <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          outBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sample_generator.sv
// Self-checking bench for poly_sample_generator against an edge-indexed behavioural model.
module tb_poly_sample_generator;

  localparam int VOICES = 4;

  logic        inCLK = 1'b0;
  logic        inRST_N;
  logic        inSampleClockCE;
  logic        inNoteValid;
  logic        inNoteOn;
  logic [1:0]  inNoteVoice;
  logic [6:0]  inNoteIndex;
  logic [1:0]  inNoteWave;
  logic [11:0] outSample;
  logic        outSampleValid;
  logic        outBusy;
  logic        outOverrun;

  poly_sample_generator #(.VOICES(4), .N(32), .M(12), .SAMPLE_CLOCK_RATE_HZ(48000)) dut (
    .inCLK           (inCLK),
    .inRST_N         (inRST_N),
    .inSampleClockCE (inSampleClockCE),
    .inNoteValid     (inNoteValid),
    .inNoteOn        (inNoteOn),
    .inNoteVoice     (inNoteVoice),
    .inNoteIndex     (inNoteIndex),
    .inNoteWave      (inNoteWave),
    .outSample       (outSample),
    .outSampleValid  (outSampleValid),
    .outBusy         (outBusy),
    .outOverrun      (outOverrun)
  );

  // ---------------- clock / reset ----------------
  always #5 inCLK = ~inCLK;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit run_check = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_gate  [VOICES];
  int          m_note  [VOICES];
  int          m_wave  [VOICES];
  logic [31:0] m_phase [VOICES];
  int          edge_n = 0;
  int          m_k;
  int          m_sum;
  bit          m_active, m_busy, m_valid, m_overrun;
  logic [11:0] m_sample;
  logic [11:0] exp_q[$];

  function automatic longint step_of(input int n);
    real f;
    f = 440.0 * $pow(2.0, (real'(n) - 69.0) / 12.0);
    return longint'(f * 4294967296.0 / 48000.0);
  endfunction

  // Signed level of one voice: offset-binary raw value minus mid-scale.
  function automatic int model_level(input bit g, input int w, input logic [31:0] ph);
    int raw;
    if (!g) return 0;
    raw = int'(ph >> 20);
    if (w == 1) raw = ph[31] ? 4095 : 0;
`ifdef POLY_SAMPLE_GENERATOR_TRIANGLE_EN
    if (w == 2) raw = ph[31] ? 4095 - int'((ph >> 19) & 32'hFFF) : int'((ph >> 19) & 32'hFFF);
`endif
    return raw - 2048;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_wave[i] = 0; m_phase[i] = '0;
    end
    m_active = 0; m_busy = 0; m_valid = 0; m_overrun = 0; m_sample = '0; m_sum = 0;
    exp_q.delete();
  endtask

  // Applies one clock edge worth of behaviour using the inputs sampled at that edge.
  task automatic model_step();
    int  slot;
    bit  busy_pre;
    if (!inRST_N) return;
    edge_n++;
    busy_pre = m_active;
    m_valid  = 0;
    if (m_active && edge_n == m_k + VOICES + 1) begin
      m_sample = 12'(m_sum >>> 2);
      m_valid  = 1;
      exp_q.push_back(m_sample);
      m_active = 0;
    end else if (m_active) begin
      slot  = edge_n - m_k - 1;
      m_sum += model_level(m_gate[slot], m_wave[slot], m_phase[slot]);
      if (m_gate[slot]) m_phase[slot] = m_phase[slot] + 32'(step_of(m_note[slot]));
    end
    if (inSampleClockCE) begin
      if (busy_pre) m_overrun = 1;
      else begin
        m_active = 1; m_k = edge_n; m_sum = 0;
      end
    end
    if (inNoteValid) begin
      if (inNoteOn) begin
        m_gate[inNoteVoice]  = 1;
        m_note[inNoteVoice]  = int'(inNoteIndex);
        m_wave[inNoteVoice]  = int'(inNoteWave);
        m_phase[inNoteVoice] = '0;
      end else begin
        m_gate[inNoteVoice] = 0;
      end
    end
    m_busy = m_active;
  endtask

  // ---------------- compare process / scoreboard ----------------
  always @(negedge inCLK) begin
    if (run_check) begin
      check("busy", outBusy, m_busy);
      check("overrun", outOverrun, m_overrun);
      check("valid", outSampleValid, m_valid);
      check("sample_hold", outSample, m_sample);
      if (outSampleValid) begin
        if (exp_q.size() == 0) check("sample_queue", exp_q.size(), 1);
        else check("sample", outSample, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit ce, input bit nv, input bit on, input int v, input int n, input int w);
    inSampleClockCE = ce;
    inNoteValid     = nv;
    inNoteOn        = on;
    inNoteVoice     = 2'(v);
    inNoteIndex     = 7'(n);
    inNoteWave      = 2'(w);
    @(posedge inCLK);
    model_step();
    @(negedge inCLK);
  endtask

  task automatic idle(input int cycles);
    for (int j = 0; j < cycles; j++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_sample(output int lat, output logic [11:0] s);
    lat = -1;
    s   = '0;
    for (int j = 1; j <= 12; j++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (outSampleValid && lat < 0) begin
        lat = j;
        s   = outSample;
      end
    end
  endtask

  // Asserts reset part-way through a cycle and checks the asynchronous clear.
  task automatic apply_reset();
    #2;
    inRST_N = 1'b0;
    inSampleClockCE = 0; inNoteValid = 0; inNoteOn = 0;
    inNoteVoice = '0; inNoteIndex = '0; inNoteWave = '0;
    #1;
    model_reset();
    check("rst_busy", outBusy, 0);
    check("rst_valid", outSampleValid, 0);
    check("rst_overrun", outOverrun, 0);
    check("rst_sample", outSample, 0);
    @(negedge inCLK);
    @(negedge inCLK);
    inRST_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic [11:0] s;
  int          pulses;

  initial begin
    inRST_N = 1'b0;
    inSampleClockCE = 0; inNoteValid = 0; inNoteOn = 0;
    inNoteVoice = '0; inNoteIndex = '0; inNoteWave = '0;
    model_reset();
    repeat (3) @(negedge inCLK);
    check("init_busy", outBusy, 0);
    check("init_valid", outSampleValid, 0);
    check("init_overrun", outOverrun, 0);
    check("init_sample", outSample, 0);
    inRST_N   = 1'b1;
    run_check = 1'b1;

    // Pin the model itself.
    check("model_step69", step_of(69), 64'd39370534);
    check("model_square_hi", 32'(model_level(1, 1, 32'h8000_0000)), 32'(2047));
    check("model_off", 32'(model_level(0, 1, 32'h8000_0000)), 32'(0));
`ifdef POLY_SAMPLE_GENERATOR_TRIANGLE_EN
    check("model_tri_c0", 32'(model_level(1, 2, 32'hC000_0000)), 32'(12'h7FF - 2048));
`else
    check("model_tri_c0", 32'(model_level(1, 2, 32'hC000_0000)), 32'(12'hC00 - 2048));
`endif

    // Voice 0, A4 saw, single strobe.
    cycle(0, 1, 1, 0, 69, 0);
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    check("a4_latency", lat, 5);
    check("a4_sample", s, 12'hE00);
    check("a4_phase", dut.phase[0], 32'd39370534);

    // All voices off.
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    check("silent_latency", lat, 5);
    check("silent_sample", s, 12'h000);

    // Voice 1 square: third sweep sees the phase MSB set.
    apply_reset();
    cycle(0, 1, 1, 1, 127, 1);
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    check("square_low", s, 12'hE00);
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    check("square_high", s, 12'h1FF);

    // Strobe while busy.
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (outSampleValid) pulses++;
    end
    check("overrun_pulses", pulses, 1);
    check("overrun_sticky", outOverrun, 1);

    // Note-on to voice 2 on its own sweep slot.
    apply_reset();
    cycle(0, 1, 1, 2, 100, 0);
    cycle(1, 0, 0, 0, 0, 0);
    wait_sample(lat, s);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 2, 60, 1);
    check("slot_phase_cleared", dut.phase[2], 32'd0);
    wait_sample(lat, s);
    check("slot_latency", lat, 2);

    // Reset in the middle of a sweep.
    apply_reset();
    cycle(0, 1, 1, 3, 80, 1);
    cycle(1, 0, 0, 0, 0, 0);
    idle(3);
    apply_reset();
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (outSampleValid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Randomized traffic, every wave code including the reserved one.
    apply_reset();
    for (int j = 0; j < 4000; j++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
    end
    idle(12);
    check("queue_drained", exp_q.size(), 0);

    run_check = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_sample_generator.md
POLY_SAMPLE_GENERATOR -- requirements
Module: poly_sample_generator

Interface
REQ-001 SHALL have parameter VOICES, default 4, meaning voice count (power of two, 2..16).
REQ-002 SHALL have parameter N, default 32, meaning phase accumulator width.
REQ-003 SHALL have parameter M, default 12, meaning sample width.
REQ-004 SHALL have parameter SAMPLE_CLOCK_RATE_HZ, default 48000, meaning sample rate used for step computation.
REQ-005 SHALL have port inCLK  input  1  meaning the single clock.
REQ-006 SHALL have port inRST_N  input  1  meaning the asynchronous, active-low reset.
REQ-007 SHALL have port inSampleClockCE  input  1  meaning one-cycle sample strobe.
REQ-008 SHALL have port inNoteValid  input  1  meaning note command strobe.
REQ-009 SHALL have port inNoteOn  input  1  meaning 1 = gate on, 0 = gate off.
REQ-010 SHALL have port inNoteVoice  input  $clog2(VOICES)  meaning target voice.
REQ-011 SHALL have port inNoteIndex  input  7  meaning MIDI note number.
REQ-012 SHALL have port inNoteWave  input  2  meaning 0 saw, 1 square, 2 triangle, 3 reserved.
REQ-013 SHALL have port outSample  output  M  meaning signed mixed sample.
REQ-014 SHALL have port outSampleValid  output  1  meaning one-cycle pulse on new sample.
REQ-015 SHALL have port outBusy  output  1  meaning sweep in progress.
REQ-016 SHALL have port outOverrun  output  1  meaning sticky flag for a strobe received while busy.

Function
REQ-017 SHALL hold, per voice, registers gate, note[6:0], wave[1:0] and phase[N-1:0].
REQ-018 SHALL, on an accepted note-on command, write note and wave, set gate and clear phase to 0 at that edge.
REQ-019 SHALL, on note-off, clear gate only; phase, note and wave hold.
REQ-020 SHALL accept note commands on any cycle, busy or not.
REQ-021 SHALL implement FSM IDLE -> SWEEP -> MIX -> IDLE.
REQ-022 SHALL leave IDLE only on inSampleClockCE.
REQ-023 SHALL, in SWEEP, process voice i at edge k+1+i, where k is the edge at which the strobe was sampled.
REQ-024 SHALL, in MIX, register outSample and pulse outSampleValid at edge k+VOICES+1 (latency VOICES+1 cycles).
REQ-025 SHALL assert outBusy whenever state != IDLE.
REQ-026 SHALL define voice processing as: phase <= phase + STEP[note] (mod 2^N) if gate; hold otherwise.
REQ-027 SHALL compute each voice's contribution from the pre-update phase.
REQ-028 SHALL define STEP[n] = round(2^N * f(n) / SAMPLE_CLOCK_RATE_HZ), with f(n) = 440 * 2^((n-69)/12), for n = 0..127.
REQ-029 SHALL compute raw waveform values as:
  - saw: phase[N-1:N-M];
  - square: all ones if phase[N-1], else 0;
  - triangle: phase[N-2:N-M-1], bitwise inverted when phase[N-1];
  - code 3: treated as saw.
REQ-030 SHALL convert each raw value to signed by inverting its MSB.
REQ-031 SHALL make a gated-off voice contribute 0.
REQ-032 SHALL accumulate contributions in M+$clog2(VOICES) signed bits.
REQ-033 SHALL drive outSample = accumulator arithmetically shifted right by $clog2(VOICES), so no overflow is possible.
REQ-034 SHALL ignore inSampleClockCE while busy and set outOverrun (sticky).
REQ-035 SHALL, when a note command and a voice's sweep slot coincide, process that slot with the pre-edge register values, with note-on phase clear taking priority over accumulation.
REQ-036 SHALL let phase wrap silently modulo 2^N.

Reset
REQ-037 SHALL, on inRST_N low, asynchronously clear all of the following:
  - gate, note, wave and phase;
  - FSM state (to IDLE) and voice counter;
  - accumulator, outSample, outSampleValid, outBusy and outOverrun.
REQ-038 SHALL abort a sweep interrupted by reset, emitting no sample after release.
REQ-039 SHALL honour the first strobe only from the first edge after release.

Configuration
REQ-040 SHALL provide macro POLY_SAMPLE_GENERATOR_TRIANGLE_EN.
  - Defined: wave code 2 produces triangle per REQ-029.
  - Undefined: code 2 produces saw, and no triangle logic is synthesised.

Structure
REQ-041 SHALL place in package synth_pkg:
  - wave-code constants (WAVE_SAW, WAVE_SQUARE, WAVE_TRI);
  - FSM state typedef;
  - constant function computing STEP[n] from N and SAMPLE_CLOCK_RATE_HZ.
REQ-042 SHALL implement the step table as sub-module freq_step_rom: 7-bit note in, N-bit step out, combinational, parameterised by N and rate.

Verification
REQ-043 SHALL cover: N=32, rate 48000, voice 0 note-on 69 saw, one strobe -> after the sweep, voice 0 phase = 39370534; outSampleValid exactly at k+5 (VOICES=4).
REQ-044 SHALL cover: all voices gated off, strobe -> outSample = 0, valid pulse at k+5.
REQ-045 SHALL cover: voice 1 square, phase MSB set, other voices off -> raw 0xFFF, signed 0x7FF, outSample = 0x7FF >>> 2 = 0x1FF.
REQ-046 SHALL cover: second strobe at k+2 -> ignored, outOverrun = 1 until reset, one valid pulse only.
REQ-047 SHALL cover: note-on to voice 2 at the same edge as voice 2's slot -> phase 0 afterwards, old note's contribution used in that sample.
REQ-048 SHALL cover: inRST_N low at k+3 -> all outputs 0 immediately, no valid pulse after release; triangle build with and without the macro, phase 0xC0000000 -> triangle 0x7FF vs saw 0xC00.
